// File: rtl/rgb_led_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rgb_led_top                                                     |
// | Purpose  : Two RGB LEDs driven by 5-bit PWM per colour; duties and LED     |
// |            select come from SW, latched once per 8192-cycle PWM period.    |
// |            Optional 8-digit seven-segment readout of the latched duties,   |
// |            built only when the macro SEG_DISPLAY_EN is defined (otherwise  |
// |            CA and AN idle at 8'hFF).                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rgb_led_top
`ifdef SEG_DISPLAY_EN
#(
  // Width of the digit-refresh counter; its top three bits pick the digit.
  parameter int REFRESH_W = 17
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] SW,
  output logic [2:0]  LED0,
  output logic [2:0]  LED1,
  output logic [7:0]  CA,
  output logic [7:0]  AN
);

  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_s;
  logic [7:0]  r_presc;
  logic        w_tick;
  logic [4:0]  r_pwm;
  logic        w_wrap;
  logic [4:0]  r_duty_r;
  logic [4:0]  r_duty_g;
  logic [4:0]  r_duty_b;
  logic        r_sel;
  logic [2:0]  w_pwm_rgb;
  logic [2:0]  r_led0;
  logic [2:0]  r_led1;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sw_meta <= 16'h0000;
      r_sw_s    <= 16'h0000;
    end else begin
      r_sw_meta <= SW;
      r_sw_s    <= r_sw_meta;
    end
  end

  // Free-running prescaler; the tick marks the 255->0 wrap.
  assign w_tick = (r_presc == 8'hFF);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_presc <= 8'h00;
    else      r_presc <= r_presc + 8'd1;
  end

  // PWM phase counter, one step per tick; wrap is the period boundary.
  assign w_wrap = w_tick && (r_pwm == 5'd31);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       r_pwm <= 5'd0;
    else if (w_tick) r_pwm <= r_pwm + 5'd1;
  end

  // Duties and LED select only change at the period boundary, so a
  // mid-period switch change never distorts the pulse in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_duty_r <= 5'd0;
      r_duty_g <= 5'd0;
      r_duty_b <= 5'd0;
      r_sel    <= 1'b0;
    end else if (w_wrap) begin
      r_duty_r <= r_sw_s[4:0];
      r_duty_g <= r_sw_s[9:5];
      r_duty_b <= r_sw_s[14:10];
      r_sel    <= r_sw_s[15];
    end
  end

  assign w_pwm_rgb = {(r_pwm < r_duty_b), (r_pwm < r_duty_g), (r_pwm < r_duty_r)};

  // Registered LED drive: selected LED carries PWM, the other stays dark.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_led0 <= 3'b000;
      r_led1 <= 3'b000;
    end else begin
      r_led0 <= r_sel ? 3'b000 : w_pwm_rgb;
      r_led1 <= r_sel ? w_pwm_rgb : 3'b000;
    end
  end

  assign LED0 = r_led0;
  assign LED1 = r_led1;

`ifdef SEG_DISPLAY_EN
  logic [REFRESH_W-1:0] r_refresh;
  logic [2:0]           w_slot;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic [7:0]           r_an;
  logic [7:0]           r_ca;

  // Tens digit of a 0-31 value.
  function automatic logic [3:0] tens_of(input logic [4:0] v);
    if (v >= 5'd30)      return 4'd3;
    else if (v >= 5'd20) return 4'd2;
    else if (v >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  // Units digit of a 0-31 value.
  function automatic logic [3:0] units_of(input logic [4:0] v);
    logic [4:0] t10;
    t10 = 5'(tens_of(v)) * 5'd10;
    return 4'(v - t10);
  endfunction

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Refresh counter; its top three bits choose the active digit position.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_refresh <= '0;
    else      r_refresh <= r_refresh + 1'b1;
  end

  assign w_slot = r_refresh[REFRESH_W-1 -: 3];

  // Map the digit position to the latched duty digit it shows.
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    case (w_slot)
      3'd7:    w_digit = tens_of(r_duty_r);
      3'd6:    w_digit = units_of(r_duty_r);
      3'd4:    w_digit = tens_of(r_duty_g);
      3'd3:    w_digit = units_of(r_duty_g);
      3'd1:    w_digit = tens_of(r_duty_b);
      3'd0:    w_digit = units_of(r_duty_b);
      default: w_blank = 1'b1;
    endcase
  end

  // Registered anode/cathode drive; blank slots leave everything off.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_an <= 8'hFF;
      r_ca <= 8'hFF;
    end else if (w_blank) begin
      r_an <= 8'hFF;
      r_ca <= 8'hFF;
    end else begin
      r_an <= ~(8'd1 << w_slot);
      r_ca <= {1'b1, seg7(w_digit)};
    end
  end

  assign AN = r_an;
  assign CA = r_ca;
`else
  // Display not built: all digits and segments stay off.
  assign AN = 8'hFF;
  assign CA = 8'hFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rgb_led_top                                                  |
// | Purpose  : Directed self-checking bench for rgb_led_top: reset state,      |
// |            per-period PWM high counts, period-boundary duty latching,      |
// |            LED select, asynchronous reset abort and display contents.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rgb_led_top;

  logic        CLK;
  logic        RST;
  logic [15:0] SW;
  logic [2:0]  LED0;
  logic [2:0]  LED1;
  logic [7:0]  CA;
  logic [7:0]  AN;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;   // rising edges since reset release

  int cnt_r0, cnt_g0, cnt_b0, cnt_l1r, cnt_l1gb, disp_bad;
  logic [7:0] seen_ca [8];

`ifdef SEG_DISPLAY_EN
  rgb_led_top #(.REFRESH_W(9)) u_dut (
    .CLK (CLK), .RST (RST), .SW (SW),
    .LED0(LED0), .LED1(LED1), .CA (CA), .AN (AN)
  );
`else
  rgb_led_top u_dut (
    .CLK (CLK), .RST (RST), .SW (SW),
    .LED0(LED0), .LED1(LED1), .CA (CA), .AN (AN)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Safety net in case the run stalls.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard digit patterns, dp off.
  function automatic logic [7:0] seg_ca(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic clear_counts();
    cnt_r0 = 0; cnt_g0 = 0; cnt_b0 = 0; cnt_l1r = 0; cnt_l1gb = 0; disp_bad = 0;
    for (int p = 0; p < 8; p++) seen_ca[p] = 8'h00;
  endtask

  // Advance to edge t_end, sampling 1 ns after each rising edge.
  task automatic step_to(input int t_end);
    while (t < t_end) begin
      @(posedge CLK);
      t++;
      #1;
      if (LED0[0]) cnt_r0++;
      if (LED0[1]) cnt_g0++;
      if (LED0[2]) cnt_b0++;
      if (LED1[0]) cnt_l1r++;
      if (LED1[2:1] != 2'b00) cnt_l1gb++;
`ifdef SEG_DISPLAY_EN
      if (AN == 8'hFF) begin
        if (CA != 8'hFF) disp_bad++;
      end else if ($countones(~AN) != 1 || !AN[2] || !AN[5]) begin
        disp_bad++;
      end else begin
        for (int p = 0; p < 8; p++) begin
          if (!AN[p]) begin
            if (seen_ca[p] == 8'h00) seen_ca[p] = CA;
            else if (seen_ca[p] != CA) disp_bad++;
          end
        end
      end
`else
      if (CA != 8'hFF || AN != 8'hFF) disp_bad++;
`endif
    end
  endtask

  task automatic check_leds(input string tag, input int r0, input int g0, input int b0,
                            input int l1r, input int l1gb);
    check_eq({tag, "_led0_r"}, cnt_r0, r0);
    check_eq({tag, "_led0_g"}, cnt_g0, g0);
    check_eq({tag, "_led0_b"}, cnt_b0, b0);
    check_eq({tag, "_led1_r"}, cnt_l1r, l1r);
    check_eq({tag, "_led1_gb"}, cnt_l1gb, l1gb);
  endtask

  task automatic check_disp(input string tag, input int rt, input int ru, input int gt,
                            input int gu, input int bt, input int bu);
    check_eq({tag, "_disp_bad"}, disp_bad, 0);
`ifdef SEG_DISPLAY_EN
    check_eq({tag, "_an7"}, seen_ca[7], seg_ca(rt));
    check_eq({tag, "_an6"}, seen_ca[6], seg_ca(ru));
    check_eq({tag, "_an4"}, seen_ca[4], seg_ca(gt));
    check_eq({tag, "_an3"}, seen_ca[3], seg_ca(gu));
    check_eq({tag, "_an1"}, seen_ca[1], seg_ca(bt));
    check_eq({tag, "_an0"}, seen_ca[0], seg_ca(bu));
`endif
  endtask

  initial begin
    RST = 1'b0;
    SW  = 16'hFFFF;
    repeat (5) @(posedge CLK);
    #1;
    check_eq("rst_led0", LED0, 3'b000);
    check_eq("rst_led1", LED1, 3'b000);
    check_eq("rst_ca", CA, 8'hFF);
    check_eq("rst_an", AN, 8'hFF);

    @(negedge CLK);
    SW = 16'h0001;
    @(negedge CLK);
    RST = 1'b1;
    t = 0;

    // Period 0: duties still 0 from reset.
    clear_counts();
    step_to(8192);
    check_leds("p0", 0, 0, 0, 0, 0);
    check_disp("p0", 0, 0, 0, 0, 0, 0);

    // Period 1: R=1; the mid-period change to R=16 must not show yet.
    clear_counts();
    step_to(12000);
    SW = 16'h0010;
    step_to(16384);
    check_leds("p1", 256, 0, 0, 0, 0);
    check_disp("p1", 0, 1, 0, 0, 0, 0);

    // Period 2: R=16 on LED0; switch to LED1, R=31 mid-period.
    clear_counts();
    step_to(20000);
    SW = 16'h801F;
    step_to(24576);
    check_leds("p2", 4096, 0, 0, 0, 0);
    check_disp("p2", 1, 6, 0, 0, 0, 0);

    // Period 3: LED1 red at 31/32, LED0 dark.
    clear_counts();
    step_to(28000);
    SW = 16'h7FFF;
    step_to(32768);
    check_leds("p3", 0, 0, 0, 7936, 0);
    check_disp("p3", 3, 1, 0, 0, 0, 0);

    // Period 4: all three colours at 31 on LED0.
    clear_counts();
    step_to(40960);
    check_leds("p4", 7936, 7936, 7936, 0, 0);
    check_disp("p4", 3, 1, 3, 1, 3, 1);

    // Mid-period reset while the LED is lit.
    step_to(45000);
    check_eq("pre_rst_led0", LED0, 3'b111);
    check_eq("pre_rst_led1", LED1, 3'b000);
    #2;
    RST = 1'b0;
    #1;
    check_eq("async_led0", LED0, 3'b000);
    check_eq("async_led1", LED1, 3'b000);
    check_eq("async_ca", CA, 8'hFF);
    check_eq("async_an", AN, 8'hFF);
    repeat (3) @(negedge CLK);
    check_eq("hold_led0", LED0, 3'b000);
    RST = 1'b1;
    t = 0;

    // First period after reset: duties back at 0, no partial pulse.
    clear_counts();
    step_to(8192);
    check_leds("pr", 0, 0, 0, 0, 0);
    check_disp("pr", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
